multi_alarm_clock: RTL and testbench

//  Parametrised clock core: hh:mm:ss timekeeping from an internal prescaler, 12/24 h display, NUM_ALARMS alarm channels.
//  Per-channel ring/stop state; optional snooze. Drives the display digit decoder and alarm output of the clock top.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/alarm_channel.sv | 122 ++++++++++++
 rtl/multi_alarm_clock.sv | 121 ++++++++++++
 tb/tb_multi_alarm_clock.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and helpers for the multi-alarm clock.
//   time_t     : packed hh:mm:ss value (h 5 bits, m 6 bits, s 6 bits)
//   alarm_st_e : per-channel alarm state
//   MAX_H / MAX_MS : largest legal hour / minute-or-second value
//   to_12h()   : 24 h hour -> 12 h display hour (0 shows as 12)
package clock_pkg;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } time_t;

  typedef enum logic [1:0] {
    AL_IDLE   = 2'd0,
    AL_RING   = 2'd1,
    AL_SNOOZE = 2'd2
  } alarm_st_e;

  localparam logic [4:0] MAX_H  = 5'd23;
  localparam logic [5:0] MAX_MS = 6'd59;

  function automatic logic [4:0] to_12h(input logic [4:0] h);
    if (h == 5'd0)       return 5'd12;
    else if (h > 5'd12)  return h - 5'd12;
    else                 return h;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored alarm time/enable plus the IDLE/RING(/SNOOZE) FSM.
// Optional feature macro: SNOOZE_EN (adds the SNOOZE state and its counter).
// Ports:
//   clk, r           clock, asynchronous active-low reset
//   tick             one-cycle strobe: the time advances on this edge
//   tick_t           the time value this tick loads (compared against the alarm)
//   stop             return to IDLE from RING or SNOOZE
//   snooze           RING -> SNOOZE (ignored unless SNOOZE_EN)
//   wr, wr_h/m/en    single-cycle write of alarm fields; forces IDLE
//   ring             channel is ringing
//   state            current FSM state, for probing
module alarm_channel
  import clock_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       r,
  input  logic       tick,
  input  time_t      tick_t,
  input  logic       stop,
  input  logic       snooze,
  input  logic       wr,
  input  logic [4:0] wr_h,
  input  logic [5:0] wr_m,
  input  logic       wr_en,
  output logic       ring,
  output alarm_st_e  state
);

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  alarm_st_e  state_q, state_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic [4:0] h_q;
  logic [5:0] m_q;
  logic       en_q;
  logic       hit;

`ifdef SNOOZE_EN
  localparam logic [11:0] SNZ_LAST = 12'(SNOOZE_MIN * 60 - 1);
  logic [11:0] scnt_q, scnt_d;
`else
  logic snooze_unused;
  assign snooze_unused = snooze;
`endif

  // Only a real tick can trigger, so a set_time landing on the alarm is silent.
  assign hit = tick && en_q && (tick_t.h == h_q) && (tick_t.m == m_q) && (tick_t.s == 6'd0);

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
`ifdef SNOOZE_EN
    scnt_d  = scnt_q;
`endif
    // Priority: write > stop > trigger > snooze > counting.
    if (wr || stop) begin
      state_d = AL_IDLE;
    end else if (hit) begin
      state_d = AL_RING;
      rcnt_d  = 8'd0;
    end else begin
      case (state_q)
        AL_RING: begin
`ifdef SNOOZE_EN
          if (snooze) begin
            state_d = AL_SNOOZE;
            scnt_d  = 12'd0;
          end else
`endif
          if (tick) begin
            if (rcnt_q == RING_LAST) state_d = AL_IDLE;
            else                     rcnt_d  = rcnt_q + 8'd1;
          end
        end
`ifdef SNOOZE_EN
        AL_SNOOZE: begin
          if (tick) begin
            if (scnt_q == SNZ_LAST) begin
              state_d = AL_RING;
              rcnt_d  = 8'd0;
            end else begin
              scnt_d = scnt_q + 12'd1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q <= AL_IDLE;
      rcnt_q  <= 8'd0;
      h_q     <= 5'd0;
      m_q     <= 6'd0;
      en_q    <= 1'b0;
`ifdef SNOOZE_EN
      scnt_q  <= 12'd0;
`endif
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
`ifdef SNOOZE_EN
      scnt_q  <= scnt_d;
`endif
      if (wr) begin
        h_q  <= wr_h;
        m_q  <= wr_m;
        en_q <= wr_en;
      end
    end
  end

  assign ring  = (state_q == AL_RING);
  assign state = state_q;

endmodule

// File: rtl/multi_alarm_clock.sv
// Clock core: prescaler, hh:mm:ss counters, 12/24 h display decode and
// NUM_ALARMS alarm channels.
// Optional feature macro: SNOOZE_EN (snooze support inside alarm_channel).
// Ports:
//   clk, r                 clock, asynchronous active-low reset
//   hour_24                1: disp_h = hh, 0: 12 h display
//   set_time, set_h/m/s    load time (out-of-range loads ignored), clears prescaler
//   al_wr, al_idx, al_h/m, al_en   single-cycle alarm channel write
//   stop, snooze           global stop / snooze for all channels
//   hh, mm, ss             current time
//   disp_h, pm             display hour and afternoon flag
//   sec_pulse              one-cycle pulse after each second tick
//   ring, a_out            per-channel ringing and their OR
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int NUM_ALARMS = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  r,
  input  logic                  hour_24,
  input  logic                  set_time,
  input  logic [4:0]            set_h,
  input  logic [5:0]            set_m,
  input  logic [5:0]            set_s,
  input  logic                  al_wr,
  input  logic [AW-1:0]         al_idx,
  input  logic [4:0]            al_h,
  input  logic [5:0]            al_m,
  input  logic                  al_en,
  input  logic                  stop,
  input  logic                  snooze,
  output logic [4:0]            hh,
  output logic [5:0]            mm,
  output logic [5:0]            ss,
  output logic [4:0]            disp_h,
  output logic                  pm,
  output logic                  sec_pulse,
  output logic [NUM_ALARMS-1:0] ring,
  output logic                  a_out
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  time_t         t_q, next_t;
  logic          set_ok, tick;

  // Per-channel FSM state, kept visible for probing.
  alarm_st_e ch_state_unused [NUM_ALARMS];

  assign set_ok = set_time && (set_h <= MAX_H) && (set_m <= MAX_MS) && (set_s <= MAX_MS);
  // A valid load in the same cycle swallows the tick.
  assign tick   = (presc_q == PRESC_LAST) && !set_ok;

  always_comb begin
    next_t = t_q;
    if (t_q.s == MAX_MS) begin
      next_t.s = 6'd0;
      if (t_q.m == MAX_MS) begin
        next_t.m = 6'd0;
        next_t.h = (t_q.h == MAX_H) ? 5'd0 : t_q.h + 5'd1;
      end else begin
        next_t.m = t_q.m + 6'd1;
      end
    end else begin
      next_t.s = t_q.s + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      presc_q   <= '0;
      t_q       <= '0;
      sec_pulse <= 1'b0;
    end else if (set_ok) begin
      presc_q   <= '0;
      t_q       <= '{h: set_h, m: set_m, s: set_s};
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= tick;
      presc_q   <= tick ? '0 : presc_q + PW'(1);
      if (tick) t_q <= next_t;
    end
  end

  // Display is a pure decode of the registered hour, so it never lags hh.
  assign hh     = t_q.h;
  assign mm     = t_q.m;
  assign ss     = t_q.s;
  assign pm     = (t_q.h >= 5'd12);
  assign disp_h = hour_24 ? t_q.h : to_12h(t_q.h);

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    alarm_channel #(
      .RING_SECS (RING_SECS),
      .SNOOZE_MIN(SNOOZE_MIN)
    ) u_ch (
      .clk   (clk),
      .r     (r),
      .tick  (tick),
      .tick_t(next_t),
      .stop  (stop),
      .snooze(snooze),
      .wr    (al_wr && (al_idx == AW'(i))),
      .wr_h  (al_h),
      .wr_m  (al_m),
      .wr_en (al_en),
      .ring  (ring[i]),
      .state (ch_state_unused[i])
    );
  end

  assign a_out = |ring;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with TICK_DIV=4, RING_SECS=3,
// SNOOZE_MIN=1, NUM_ALARMS=4. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
module tb_multi_alarm_clock;

  logic       clk = 1'b0;
  logic       r = 1'b0;
  logic       hour_24 = 1'b0;
  logic       set_time = 1'b0;
  logic [4:0] set_h = '0;
  logic [5:0] set_m = '0;
  logic [5:0] set_s = '0;
  logic       al_wr = 1'b0;
  logic [1:0] al_idx = '0;
  logic [4:0] al_h = '0;
  logic [5:0] al_m = '0;
  logic       al_en = 1'b0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic [4:0] disp_h;
  logic       pm;
  logic       sec_pulse;
  logic [3:0] ring;
  logic       a_out;

  int n_checks = 0;
  int n_fail   = 0;

  multi_alarm_clock #(
    .TICK_DIV(4), .NUM_ALARMS(4), .RING_SECS(3), .SNOOZE_MIN(1)
  ) dut (
    .clk(clk), .r(r), .hour_24(hour_24),
    .set_time(set_time), .set_h(set_h), .set_m(set_m), .set_s(set_s),
    .al_wr(al_wr), .al_idx(al_idx), .al_h(al_h), .al_m(al_m), .al_en(al_en),
    .stop(stop), .snooze(snooze),
    .hh(hh), .mm(mm), .ss(ss), .disp_h(disp_h), .pm(pm),
    .sec_pulse(sec_pulse), .ring(ring), .a_out(a_out)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: test did not complete in time");
    $fatal(1, "watchdog");
  end

  // Checking
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, ".hh"}, int'(hh), h);
    chk({name, ".mm"}, int'(mm), m);
    chk({name, ".ss"}, int'(ss), s);
  endtask

  // Drivers (called at a falling edge, return at a falling edge)
  task automatic set_clock(input int h, input int m, input int s);
    set_h = 5'(h);
    set_m = 6'(m);
    set_s = 6'(s);
    set_time = 1'b1;
    @(negedge clk);
    set_time = 1'b0;
  endtask

  task automatic wr_alarm(input int idx, input int h, input int m, input bit en);
    al_idx = 2'(idx);
    al_h   = 5'(h);
    al_m   = 6'(m);
    al_en  = en;
    al_wr  = 1'b1;
    @(negedge clk);
    al_wr  = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  typedef struct {
    int h, m, s;
    bit h24;
    int ticks;
    int eh, em, es, edisp;
    bit epm;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{h: 23, m: 59, s: 59, h24: 1, ticks: 1, eh: 0,  em: 0,  es: 0, edisp: 0,  epm: 0};
    vecs[1] = '{h: 0,  m: 0,  s: 0,  h24: 0, ticks: 0, eh: 0,  em: 0,  es: 0, edisp: 12, epm: 0};
    vecs[2] = '{h: 12, m: 0,  s: 0,  h24: 0, ticks: 0, eh: 12, em: 0,  es: 0, edisp: 12, epm: 1};
    vecs[3] = '{h: 13, m: 0,  s: 0,  h24: 0, ticks: 0, eh: 13, em: 0,  es: 0, edisp: 1,  epm: 1};
    vecs[4] = '{h: 13, m: 0,  s: 0,  h24: 1, ticks: 0, eh: 13, em: 0,  es: 0, edisp: 13, epm: 1};
    vecs[5] = '{h: 11, m: 59, s: 59, h24: 0, ticks: 1, eh: 12, em: 0,  es: 0, edisp: 12, epm: 1};
    vecs[6] = '{h: 0,  m: 59, s: 59, h24: 1, ticks: 1, eh: 1,  em: 0,  es: 0, edisp: 1,  epm: 0};
    vecs[7] = '{h: 10, m: 20, s: 58, h24: 0, ticks: 2, eh: 10, em: 21, es: 0, edisp: 10, epm: 0};
    vecs[8] = '{h: 23, m: 0,  s: 0,  h24: 0, ticks: 0, eh: 23, em: 0,  es: 0, edisp: 11, epm: 1};

    // Reset
    repeat (2) @(negedge clk);
    hour_24 = 1'b1;
    #1;
    chk("rst.disp24", int'(disp_h), 0);
    hour_24 = 1'b0;
    @(negedge clk);
    chk("rst.disp12", int'(disp_h), 12);
    r = 1'b1;
    chk_time("rst", 0, 0, 0);
    chk("rst.ring", int'(ring), 0);
    chk("rst.a_out", int'(a_out), 0);
    chk("rst.sec_pulse", int'(sec_pulse), 0);
    chk("rst.pm", int'(pm), 0);

    // Second pulse every 4 clocks
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("pulse.c%0d", i), int'(sec_pulse), (i % 4 == 0) ? 1 : 0);
      if (i == 4) chk("pulse.ss1", int'(ss), 1);
    end
    chk("pulse.ss2", int'(ss), 2);

    // Table: load, let some ticks pass, check time and display
    for (int v = 0; v < 9; v++) begin
      hour_24 = vecs[v].h24;
      set_clock(vecs[v].h, vecs[v].m, vecs[v].s);
      repeat (vecs[v].ticks * 4) @(negedge clk);
      chk_time($sformatf("vec%0d", v), vecs[v].eh, vecs[v].em, vecs[v].es);
      chk($sformatf("vec%0d.disp_h", v), int'(disp_h), vecs[v].edisp);
      chk($sformatf("vec%0d.pm", v), int'(pm), int'(vecs[v].epm));
    end
    hour_24 = 1'b1;

    // set_time on the tick edge wins; invalid loads are ignored
    set_clock(0, 0, 0);
    repeat (3) @(negedge clk);
    set_clock(5, 6, 7);
    chk_time("set_vs_tick", 5, 6, 7);
    set_clock(24, 0, 0);
    chk_time("bad_hour", 5, 6, 7);
    set_clock(5, 60, 0);
    chk_time("bad_min", 5, 6, 7);

    // Channel 2 at 00:01, single ring of 3 seconds
    wr_alarm(2, 0, 1, 1'b1);
    set_clock(0, 0, 59);
    repeat (3) @(negedge clk);
    chk("ch2.before", int'(ring), 0);
    @(negedge clk);
    chk("ch2.ring", int'(ring), 'b0100);
    chk("ch2.a_out", int'(a_out), 1);
    chk_time("ch2.time", 0, 1, 0);
    repeat (8) @(negedge clk);
    chk("ch2.still", int'(ring), 'b0100);
    repeat (4) @(negedge clk);
    chk("ch2.auto_stop", int'(ring), 0);
    chk("ch2.a_out_off", int'(a_out), 0);
    set_clock(0, 1, 0);
    chk("ch2.set_match", int'(ring), 0);
    repeat (4) @(negedge clk);
    chk("ch2.set_match_later", int'(ring), 0);

    // Channels 0 and 3 together; stop; write to a ringing channel
    wr_alarm(2, 0, 1, 1'b0);
    wr_alarm(0, 2, 0, 1'b1);
    wr_alarm(3, 2, 0, 1'b1);
    set_clock(1, 59, 59);
    repeat (4) @(negedge clk);
    chk("dual.ring", int'(ring), 'b1001);
    chk("dual.a_out", int'(a_out), 1);
    pulse_stop();
    chk("dual.stop", int'(ring), 0);
    chk("dual.stop_a_out", int'(a_out), 0);
    set_clock(1, 59, 59);
    repeat (4) @(negedge clk);
    chk("dual.ring2", int'(ring), 'b1001);
    wr_alarm(0, 2, 0, 1'b1);
    chk("dual.wr_drop", int'(ring), 'b1000);
    pulse_stop();
    chk("dual.stop2", int'(ring), 0);

    // Snooze (channel 0 disabled, channel 3 rings)
    wr_alarm(0, 2, 0, 1'b0);
    set_clock(1, 59, 59);
    repeat (4) @(negedge clk);
    chk("snz.ring", int'(ring), 'b1000);
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
`ifdef SNOOZE_EN
    chk("snz.off", int'(ring), 0);
    repeat (238) @(negedge clk);
    chk("snz.59_ticks", int'(ring), 0);
    @(negedge clk);
    chk("snz.back", int'(ring), 'b1000);
    stop = 1'b1;
    snooze = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    snooze = 1'b0;
    chk("snz.stop_wins", int'(ring), 0);
    repeat (250) @(negedge clk);
    chk("snz.stays_idle", int'(ring), 0);
`else
    chk("snz.ignored", int'(ring), 'b1000);
    pulse_stop();
    chk("snz.stop", int'(ring), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
